// File: rtl/i2c_slave_byte_ctl_pkg.sv
// rtl/i2c_slave_byte_ctl_pkg.sv - shared state encodings and helpers for the I2C target controller
package i2c_slave_byte_ctl_pkg;

    // FSM state encodings
    localparam logic [3:0] I2C_SLV_IDLE     = 4'd0;
    localparam logic [3:0] I2C_SLV_ADDR     = 4'd1;
    localparam logic [3:0] I2C_SLV_ADDR_ACK = 4'd2;
    localparam logic [3:0] I2C_SLV_RX       = 4'd3;
    localparam logic [3:0] I2C_SLV_RX_ACK   = 4'd4;
    localparam logic [3:0] I2C_SLV_TX_LOAD  = 4'd5;
    localparam logic [3:0] I2C_SLV_TX       = 4'd6;
    localparam logic [3:0] I2C_SLV_TX_ACK   = 4'd7;
    localparam logic [3:0] I2C_SLV_IGNORE   = 4'd8;

    // Bit counter values: index of the last data bit, and "all 8 bits done"
    localparam logic [3:0] I2C_SLV_LAST_BIT = 4'd7;
    localparam logic [3:0] I2C_SLV_BYTE_END = 4'd8;

    // 2-of-3 majority vote used by the glitch filter
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/i2c_slave_filter.sv
// rtl/i2c_slave_filter.sv - sampled majority filter with SCL edge and START/STOP detection
module i2c_slave_filter
    import i2c_slave_byte_ctl_pkg::*;
(
    input  logic       i_sysclk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [5:0] i_dfsr,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda,
    output logic       o_scl_rise,
    output logic       o_scl_fall,
    output logic       o_start,
    output logic       o_stop
);

    logic [5:0] cnt_q;
    logic [5:0] dfsr_q;
    logic [2:0] scl_sr_q;
    logic [2:0] sda_sr_q;
    logic       scl_f_q;
    logic       sda_f_q;
    logic       scl_d1_q;
    logic       sda_d1_q;
    logic       tick;

    // The divider compares against a copy of i_dfsr taken at each wrap, so a
    // new divider value never truncates the period already in progress.
    assign tick = (cnt_q == dfsr_q);

    // Sample divider, 3-deep sample shifts, majority output and one-cycle history
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q    <= 6'd0;
            dfsr_q   <= 6'd0;
            scl_sr_q <= 3'b111;
            sda_sr_q <= 3'b111;
            scl_f_q  <= 1'b1;
            sda_f_q  <= 1'b1;
            scl_d1_q <= 1'b1;
            sda_d1_q <= 1'b1;
        end else if (!i_enable) begin
            cnt_q    <= 6'd0;
            dfsr_q   <= 6'd0;
            scl_sr_q <= 3'b111;
            sda_sr_q <= 3'b111;
            scl_f_q  <= 1'b1;
            sda_f_q  <= 1'b1;
            scl_d1_q <= 1'b1;
            sda_d1_q <= 1'b1;
        end else begin
            if (tick) begin
                cnt_q    <= 6'd0;
                dfsr_q   <= i_dfsr;
                scl_sr_q <= {scl_sr_q[1:0], i_scl};
                sda_sr_q <= {sda_sr_q[1:0], i_sda};
            end else begin
                cnt_q <= cnt_q + 6'd1;
            end
            scl_f_q  <= maj3(scl_sr_q);
            sda_f_q  <= maj3(sda_sr_q);
            scl_d1_q <= scl_f_q;
            sda_d1_q <= sda_f_q;
        end
    end

    assign o_sda      = sda_f_q;
    assign o_scl_rise = scl_f_q & ~scl_d1_q;
    assign o_scl_fall = ~scl_f_q & scl_d1_q;
    // SCL must have been high for a full cycle already: an SDA change that
    // lands together with an SCL edge is a data transition, not START/STOP.
    assign o_start    = sda_d1_q & ~sda_f_q & scl_f_q & scl_d1_q;
    assign o_stop     = ~sda_d1_q & sda_f_q & scl_f_q & scl_d1_q;

endmodule

// File: rtl/i2c_slave_byte_ctl.sv
// rtl/i2c_slave_byte_ctl.sv - byte-level I2C target: address match, receive, transmit with clock stretching
module i2c_slave_byte_ctl
    import i2c_slave_byte_ctl_pkg::*;
(
    input  logic       i_sysclk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [5:0] i_dfsr,
    input  logic [6:0] i_slave_addr,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    input  logic       i_rx_nak,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_tx_req,
    output logic       o_addr_match,
    output logic       o_rw,
    output logic       o_master_nak,
    output logic       o_start,
    output logic       o_stop,
    output logic       o_busy,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_scl,
    output logic       o_sda,
    output logic       o_scl_oen,
    output logic       o_sda_oen
);

    logic       sda_f;
    logic       scl_rise;
    logic       scl_fall;
    logic       bus_start;
    logic       bus_stop;

    logic [3:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oen_q, sda_oen_d;
    logic       scl_oen_q, scl_oen_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       addr_match_q, addr_match_d;
    logic       master_nak_q, master_nak_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       enter_load;

    i2c_slave_filter u_filter (
        .i_sysclk   (i_sysclk),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_dfsr     (i_dfsr),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_sda      (sda_f),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall),
        .o_start    (bus_start),
        .o_stop     (bus_stop)
    );

    // Next-state logic: bus conditions first, then per-state bit handling
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        sda_oen_d    = sda_oen_q;
        scl_oen_d    = scl_oen_q;
        rw_d         = rw_q;
        busy_d       = busy_q;
        rx_valid_d   = 1'b0;
        tx_req_d     = 1'b0;
        addr_match_d = 1'b0;
        master_nak_d = 1'b0;
        start_d      = 1'b0;
        stop_d       = 1'b0;
        enter_load   = 1'b0;

        if (bus_start) begin
            state_d   = I2C_SLV_ADDR;
            bit_cnt_d = 4'd0;
            sda_oen_d = 1'b1;
            scl_oen_d = 1'b1;
            busy_d    = 1'b1;
            start_d   = 1'b1;
        end else if (bus_stop) begin
            state_d   = I2C_SLV_IDLE;
            bit_cnt_d = 4'd0;
            sda_oen_d = 1'b1;
            scl_oen_d = 1'b1;
            busy_d    = 1'b0;
            stop_d    = 1'b1;
        end else begin
            case (state_q)
                I2C_SLV_ADDR: begin
                    if (scl_rise && bit_cnt_q < I2C_SLV_BYTE_END) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == I2C_SLV_LAST_BIT) begin
                            if (shift_q[6:0] == i_slave_addr) begin
                                addr_match_d = 1'b1;
                                rw_d         = sda_f;
                            end else begin
                                state_d = I2C_SLV_IGNORE;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == I2C_SLV_BYTE_END) begin
                        sda_oen_d = 1'b0;
                        state_d   = I2C_SLV_ADDR_ACK;
                    end
                end
                I2C_SLV_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oen_d = 1'b1;
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            enter_load = 1'b1;
                        end else begin
                            state_d = I2C_SLV_RX;
                        end
                    end
                end
                I2C_SLV_RX: begin
                    if (scl_rise && bit_cnt_q < I2C_SLV_BYTE_END) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == I2C_SLV_LAST_BIT) begin
                            rx_data_d  = {shift_q[6:0], sda_f};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == I2C_SLV_BYTE_END) begin
                        sda_oen_d = i_rx_nak;
                        bit_cnt_d = 4'd0;
                        state_d   = I2C_SLV_RX_ACK;
                    end
                end
                I2C_SLV_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oen_d = 1'b1;
                        state_d   = I2C_SLV_RX;
                    end
                end
                I2C_SLV_TX_LOAD: begin
                    enter_load = 1'b1;
                end
                I2C_SLV_TX: begin
                    // Bit 7 went out at load time; each fall presents the next bit,
                    // and the 8th fall hands SDA back for the master's ACK.
                    if (scl_fall) begin
                        if (bit_cnt_q == I2C_SLV_LAST_BIT) begin
                            sda_oen_d = 1'b1;
                            bit_cnt_d = 4'd0;
                            state_d   = I2C_SLV_TX_ACK;
                        end else begin
                            sda_oen_d = shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b1};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                I2C_SLV_TX_ACK: begin
                    if (scl_rise && sda_f) begin
                        master_nak_d = 1'b1;
                        state_d      = I2C_SLV_IGNORE;
                    end else if (scl_fall) begin
                        enter_load = 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // Load the next transmit byte, or hold SCL low until one is offered
            if (enter_load) begin
                if (i_tx_valid) begin
                    tx_req_d  = 1'b1;
                    shift_d   = {i_tx_data[6:0], 1'b1};
                    sda_oen_d = i_tx_data[7];
                    scl_oen_d = 1'b1;
                    bit_cnt_d = 4'd0;
                    state_d   = I2C_SLV_TX;
                end else begin
                    scl_oen_d = 1'b0;
                    state_d   = I2C_SLV_TX_LOAD;
                end
            end
        end

        // Disable discards everything, including a partial byte
        if (!i_enable) begin
            state_d      = I2C_SLV_IDLE;
            bit_cnt_d    = 4'd0;
            shift_d      = 8'h00;
            rx_data_d    = 8'h00;
            sda_oen_d    = 1'b1;
            scl_oen_d    = 1'b1;
            rw_d         = 1'b0;
            busy_d       = 1'b0;
            rx_valid_d   = 1'b0;
            tx_req_d     = 1'b0;
            addr_match_d = 1'b0;
            master_nak_d = 1'b0;
            start_d      = 1'b0;
            stop_d       = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= I2C_SLV_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            sda_oen_q    <= 1'b1;
            scl_oen_q    <= 1'b1;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
            rx_valid_q   <= 1'b0;
            tx_req_q     <= 1'b0;
            addr_match_q <= 1'b0;
            master_nak_q <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            sda_oen_q    <= sda_oen_d;
            scl_oen_q    <= scl_oen_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
            rx_valid_q   <= rx_valid_d;
            tx_req_q     <= tx_req_d;
            addr_match_q <= addr_match_d;
            master_nak_q <= master_nak_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
        end
    end

    assign o_rx_data    = rx_data_q;
    assign o_rx_valid   = rx_valid_q;
    assign o_tx_req     = tx_req_q;
    assign o_addr_match = addr_match_q;
    assign o_rw         = rw_q;
    assign o_master_nak = master_nak_q;
    assign o_start      = start_q;
    assign o_stop       = stop_q;
    assign o_busy       = busy_q;
    assign o_scl        = 1'b0;
    assign o_sda        = 1'b0;
    assign o_scl_oen    = scl_oen_q;
    assign o_sda_oen    = sda_oen_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctl.sv
// tb/tb_i2c_slave_byte_ctl.sv - directed bench: bus master model against the I2C target controller
module tb_i2c_slave_byte_ctl;
    import i2c_slave_byte_ctl_pkg::*;

    localparam int QC     = 10;
    localparam int BUDGET = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [5:0] dfsr = 6'd1;
    logic [6:0] own_addr = 7'h50;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_nak = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, addr_match, rw, master_nak, start_p, stop_p, busy;
    logic       scl_o, sda_o, scl_oen, sda_oen;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       bus_scl, bus_sda;

    int n_checks = 0;
    int n_errors = 0;
    int n_to = 0;

    int n_start = 0, n_stop = 0, n_addr = 0, n_rxv = 0, n_txreq = 0, n_nak = 0;
    int n_scl_low = 0, n_sda_low = 0, n_long = 0;
    logic [7:0] rx_log [0:7];
    logic [5:0] prev_pulses = 6'd0;

    logic [7:0] tx_buf [0:7];
    int tx_wr = 0;
    int tx_rd = 0;
    int tx_delay_cfg = 0;
    int tx_wait = 0;

    assign bus_scl = m_scl & scl_oen;
    assign bus_sda = m_sda & sda_oen;

    always #5 clk = ~clk;

    i2c_slave_byte_ctl dut (
        .i_sysclk     (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_dfsr       (dfsr),
        .i_slave_addr (own_addr),
        .i_tx_data    (tx_data),
        .i_tx_valid   (tx_valid),
        .i_rx_nak     (rx_nak),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .o_tx_req     (tx_req),
        .o_addr_match (addr_match),
        .o_rw         (rw),
        .o_master_nak (master_nak),
        .o_start      (start_p),
        .o_stop       (stop_p),
        .o_busy       (busy),
        .i_scl        (bus_scl),
        .i_sda        (bus_sda),
        .o_scl        (scl_o),
        .o_sda        (sda_o),
        .o_scl_oen    (scl_oen),
        .o_sda_oen    (sda_oen)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event counters sampled on the falling edge, plus pulse-width watch
    always @(negedge clk) begin
        logic [5:0] pulses;
        pulses = {rx_valid, tx_req, addr_match, master_nak, start_p, stop_p};
        if ((pulses & prev_pulses) != 6'd0) n_long++;
        prev_pulses = pulses;
        if (start_p)    n_start++;
        if (stop_p)     n_stop++;
        if (addr_match) n_addr++;
        if (tx_req)     n_txreq++;
        if (master_nak) n_nak++;
        if (!scl_oen)   n_scl_low++;
        if (!sda_oen)   n_sda_low++;
        if (rx_valid) begin
            if (n_rxv < 8) rx_log[n_rxv] = rx_data;
            n_rxv++;
        end
    end

    // Transmit data source; the programmed delay only elapses while SCL is stretched
    always @(negedge clk) begin
        if (tx_req) begin
            tx_valid = 1'b0;
            tx_rd++;
        end
        if (!tx_valid && tx_rd < tx_wr) begin
            if (tx_wait >= tx_delay_cfg) begin
                tx_valid = 1'b1;
                tx_data  = tx_buf[tx_rd];
                tx_wait  = 0;
            end else if (!scl_oen) begin
                tx_wait++;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_q();
        repeat (QC) @(negedge clk);
    endtask

    task automatic scl_up();
        int w;
        w = 0;
        m_scl = 1'b1;
        while (!bus_scl && w < ((n_to > 0) ? 0 : BUDGET)) begin
            @(negedge clk);
            w++;
        end
        if (!bus_scl) n_to++;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        scl_up();     wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        scl_up();     wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    wait_q();
        scl_up();     wait_q(); wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_q();
        scl_up();     wait_q();
        b = bus_sda;  wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nak);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nak);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d1, d2;
        int         sda_base;

        repeat (3) @(negedge clk);
        check("rst_scl_oen", scl_oen, 1'b1);
        check("rst_sda_oen", sda_oen, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rw", rw, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {rx_valid, tx_req, addr_match, master_nak, start_p, stop_p}, 6'd0);
        check("rst_pads", {scl_o, sda_o}, 2'b00);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Write 0xA5, 0x3C to 0x50
        i2c_start();
        check("t1_busy", busy, 1'b1);
        write_byte(8'hA0, ack); check("t1_addr_ack", ack, 1'b0);
        write_byte(8'hA5, ack); check("t1_d0_ack", ack, 1'b0);
        write_byte(8'h3C, ack); check("t1_d1_ack", ack, 1'b0);
        i2c_stop();
        wait_q();
        check("t1_rx_count", n_rxv, 2);
        check("t1_rx0", rx_log[0], 8'hA5);
        check("t1_rx1", rx_log[1], 8'h3C);
        check("t1_rw", rw, 1'b0);
        check("t1_addr_match", n_addr, 1);
        check("t1_stop", n_stop, 1);
        check("t1_busy_clr", busy, 1'b0);

        // Foreign address 0x51: ignored until STOP
        sda_base = n_sda_low;
        i2c_start();
        write_byte(8'hA2, ack); check("t2_addr_nak", ack, 1'b1);
        write_byte(8'h00, ack); check("t2_data_nak", ack, 1'b1);
        check("t2_state", dut.state_q, I2C_SLV_IGNORE);
        i2c_stop();
        wait_q();
        check("t2_sda_never_low", n_sda_low - sda_base, 0);
        check("t2_addr_match", n_addr, 1);
        check("t2_rx_count", n_rxv, 2);

        // Read with data offered 40 stretched clocks late
        tx_delay_cfg = 40;
        tx_buf[0] = 8'hC3; tx_wr = 1;
        i2c_start();
        write_byte(8'hA1, ack); check("t3_addr_ack", ack, 1'b0);
        check("t3_rw", rw, 1'b1);
        read_byte(d1, 1'b1);
        check("t3_data", d1, 8'hC3);
        check("t3_stretch", n_scl_low, 41);
        check("t3_tx_req", n_txreq, 1);
        i2c_stop();
        wait_q();
        check("t3_master_nak", n_nak, 1);

        // Two-byte read with data ready: no stretch, ACK then NAK
        tx_delay_cfg = 0;
        tx_buf[1] = 8'h5A; tx_buf[2] = 8'h96; tx_wr = 3;
        repeat (4) @(negedge clk);
        i2c_start();
        write_byte(8'hA1, ack); check("t4_addr_ack", ack, 1'b0);
        read_byte(d1, 1'b0);
        read_byte(d2, 1'b1);
        check("t4_d0", d1, 8'h5A);
        check("t4_d1", d2, 8'h96);
        check("t4_tx_req", n_txreq, 3);
        check("t4_master_nak", n_nak, 2);
        check("t4_no_stretch", n_scl_low, 41);
        check("t4_sda_released", sda_oen, 1'b1);
        i2c_stop();
        wait_q();

        // Write with NAK on byte 2, repeated START, then read
        tx_buf[3] = 8'hE7; tx_wr = 4;
        i2c_start();
        write_byte(8'hA0, ack); check("t5_addr_ack", ack, 1'b0);
        write_byte(8'h11, ack); check("t5_d0_ack", ack, 1'b0);
        rx_nak = 1'b1;
        write_byte(8'h22, ack); check("t5_d1_nak", ack, 1'b1);
        rx_nak = 1'b0;
        i2c_start();
        check("t5_start_count", n_start, 6);
        write_byte(8'hA1, ack); check("t5_raddr_ack", ack, 1'b0);
        check("t5_rw", rw, 1'b1);
        read_byte(d1, 1'b1);
        check("t5_rdata", d1, 8'hE7);
        i2c_stop();
        wait_q();
        check("t5_rx_count", n_rxv, 4);
        check("t5_rx3", rx_log[3], 8'h22);

        // Reset in the middle of bit 4 of a received byte
        i2c_start();
        write_byte(8'hA0, ack); check("t6_addr_ack", ack, 1'b0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        m_sda = 1'b0; wait_q();
        scl_up(); wait_q();
        check("t6_pre_state", dut.state_q, I2C_SLV_RX);
        rst = 1'b1;
        #1;
        check("t6_scl_oen", scl_oen, 1'b1);
        check("t6_sda_oen", sda_oen, 1'b1);
        check("t6_state", dut.state_q, I2C_SLV_IDLE);
        check("t6_rx_data", rx_data, 8'h00);
        check("t6_busy", busy, 1'b0);
        m_scl = 1'b1; m_sda = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        check("pulse_width", n_long, 0);
        check("scl_timeouts", n_to, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
